// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//   Round-robin scheduler that shares one UART transmitter core between
//   2**ID_W byte producers. One byte is accepted per grant. The scheduler
//   drives the core's start/data inputs, then waits for a rising edge on the
//   core's finish output. A transfer whose finish edge never arrives is
//   aborted after TIMEOUT_CYCLES cycles.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester "byte available", held until req_ready
//   req_data     byte of requester i at [8*i+7:8*i]
//   req_ready    one-hot, one-cycle accept pulse
//   tx_start     start strobe to the core, high START_WIDTH cycles
//   tx_data      byte to the core, stable from start until the end of WAIT
//   tx_finish    finish from the core; only its rising edge is used
//   busy         high whenever the scheduler is not idle
//   grant_id     index of the requester currently or last served
//   timeout_err  one-cycle pulse when a transfer is aborted
//
// Configuration
//   UART_TX_SCHED_HDR_EN : when defined, each grant sends a header byte
//   {4'hA, grant_id} ahead of the data byte. req_ready still pulses once,
//   and a timeout in either wait phase aborts the whole pair.
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int          ID_W           = 2,
    parameter logic [3:0]  START_WIDTH    = 4'd2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(1<<ID_W)-1:0]      req_valid,
    input  logic [8*(1<<ID_W)-1:0]    req_data,
    output logic [(1<<ID_W)-1:0]      req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_finish,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);

    localparam int NUM_REQ = 1 << ID_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         start_cnt_q, start_cnt_d;
    logic [31:0]        wait_cnt_q, wait_cnt_d;
    logic               fin_d_q;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
`ifdef UART_TX_SCHED_HDR_EN
    logic               hdr_phase_q, hdr_phase_d;
    logic [7:0]         data_byte_q, data_byte_d;
`endif

    logic               fin_rise;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;

    assign fin_rise = tx_finish & ~fin_d_q;

    // Round-robin search starting one past the last winner; the ID_W-bit
    // addition wraps naturally, so offset NUM_REQ revisits last_grant itself.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_grant_q + ID_W'(i);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        req_ready_d   = '0;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        timeout_err_d = 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
        hdr_phase_d   = hdr_phase_q;
        data_byte_d   = data_byte_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
`ifdef UART_TX_SCHED_HDR_EN
                    tx_data_d   = {4'hA, 4'(winner)};
                    data_byte_d = req_data[8*winner +: 8];
                    hdr_phase_d = 1'b1;
`else
                    tx_data_d   = req_data[8*winner +: 8];
`endif
                    grant_id_d          = winner;
                    last_grant_d        = winner;
                    req_ready_d[winner] = 1'b1;
                    tx_start_d          = 1'b1;
                    start_cnt_d         = 4'd1;
                    state_d             = S_START;
                end
            end
            // start_cnt counts the cycles tx_start has already been high.
            S_START: begin
                if (start_cnt_q >= START_WIDTH) begin
                    tx_start_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            // Finish is checked before the timeout so it wins a tie.
            S_WAIT: begin
                if (fin_rise) begin
`ifdef UART_TX_SCHED_HDR_EN
                    if (hdr_phase_q) begin
                        hdr_phase_d = 1'b0;
                        tx_data_d   = data_byte_q;
                        tx_start_d  = 1'b1;
                        start_cnt_d = 4'd1;
                        state_d     = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else if (wait_cnt_q >= TIMEOUT_CYCLES - 32'd1) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
`ifdef UART_TX_SCHED_HDR_EN
                    hdr_phase_d   = 1'b0;
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            fin_d_q       <= 1'b0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_phase_q   <= 1'b0;
            data_byte_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            fin_d_q       <= tx_finish;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_phase_q   <= hdr_phase_d;
            data_byte_q   <= data_byte_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule
